// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the sequential carry-propagate resolver.
package csa_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int N_DEF   = 16;
   localparam int SEG_DEF = 4;
   localparam int NSEG    = N_DEF / SEG_DEF;

   // Segment counter width; never narrower than one bit so NSEG=1 still builds.
   function automatic int cnt_w(input int nseg);
      return (nseg > 1) ? $clog2(nseg) : 1;
   endfunction

   localparam int CNT_W = cnt_w(NSEG);

endpackage

// File: rtl/cpa_seq_resolve_if.sv
// Operand-in / result-out handshake bundle for cpa_seq_resolve.
interface cpa_seq_resolve_if
   import csa_pkg::*;
   #(parameter int N = N_DEF) ();

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] num1;
   logic [N-1:0] num2;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;

   // Resolver side.
   modport slave (
      input  in_valid, num1, num2, out_ready,
      output in_ready, out_valid, sum, cout
   );

   // Producer/consumer side.
   modport master (
      output in_valid, num1, num2, out_ready,
      input  in_ready, out_valid, sum, cout
   );

endinterface

// File: rtl/cpa_seq_resolve_seg_adder.sv
// Combinational SEG-bit adder with carry in and carry out.
module seg_adder #(
   parameter int SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] s,
   output logic           cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/cpa_seq_resolve.sv
// Sequential carry-propagate resolver: adds a carry-save pair SEG bits per
// cycle through a registered inter-segment carry.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | waiting for an operand pair, in_ready=1
//   ST_BUSY | resolving segment seg_cnt_q, one segment per cycle
//   ST_DONE | sum/cout valid and frozen until out_ready
module cpa_seq_resolve
   import csa_pkg::*;
   #(
   parameter int N   = N_DEF,
   parameter int SEG = SEG_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   cpa_seq_resolve_if.slave bus
);

   localparam int NSEG_L = N / SEG;
   localparam int CW     = cnt_w(NSEG_L);

   state_t          state_q, state_d;
   logic [CW-1:0]   seg_cnt_q;
   logic [N-1:0]    num1_q, num2_q;
   logic [N-1:0]    sum_q;
   logic            carry_q;
   logic            cout_q;

   logic [SEG-1:0]  seg_a, seg_b, seg_s;
   logic            seg_c;
   logic            last_seg;
   logic            in_ready_c, out_valid_c;

   // Select the current operand segment with constant slices only.
   always_comb begin
      seg_a = '0;
      seg_b = '0;
      for (int i = 0; i < NSEG_L; i++) begin
         if (seg_cnt_q == CW'(i)) begin
            seg_a = num1_q[i*SEG +: SEG];
            seg_b = num2_q[i*SEG +: SEG];
         end
      end
   end

   seg_adder #(.SEG(SEG)) u_seg_adder (
      .a    (seg_a),
      .b    (seg_b),
      .cin  (carry_q),
      .s    (seg_s),
      .cout (seg_c)
   );

   assign last_seg = (seg_cnt_q == CW'(NSEG_L - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake decode; outputs depend on state_q only.
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (last_seg) state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Operand capture, segment counter, carry chain and result assembly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         num1_q    <= '0;
         num2_q    <= '0;
         seg_cnt_q <= '0;
         carry_q   <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  num1_q    <= bus.num1;
                  num2_q    <= bus.num2;
                  carry_q   <= 1'b0;
                  seg_cnt_q <= '0;
               end
            end
            ST_BUSY: begin
               carry_q <= seg_c;
               for (int i = 0; i < NSEG_L; i++) begin
                  if (seg_cnt_q == CW'(i)) sum_q[i*SEG +: SEG] <= seg_s;
               end
               if (last_seg) begin
                  seg_cnt_q <= '0;
                  cout_q    <= seg_c;
               end else begin
                  seg_cnt_q <= seg_cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule

// File: tb/tb_cpa_seq_resolve.sv
// Bench for cpa_seq_resolve (N=16, SEG=4) with a plain-arithmetic reference.
module tb_cpa_seq_resolve;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   cpa_seq_resolve_if #(.N(16)) bus ();

   cpa_seq_resolve #(.N(16), .SEG(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: unsigned 17-bit sum of the pair.
   function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   // Behavioural 4:2 compressor (two 3:2 levels) feeding the resolver.
   function automatic void comp4_2(input logic [15:0] a, b, c, d,
                                   output logic [15:0] cv, output logic [15:0] sv);
      logic [15:0] s1, c1;
      s1 = a ^ b ^ c;
      c1 = ((a & b) | (a & c) | (b & c)) << 1;
      sv = s1 ^ c1 ^ d;
      cv = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
   endfunction

   // Issue one operand pair and wait for out_valid; returns at the negedge
   // where out_valid was first seen (lat = edges after capture).
   task automatic do_op(input logic [15:0] n1, input logic [15:0] n2,
                        output int lat, output logic [15:0] s, output logic c,
                        output bit to);
      int w;
      to = 1'b0; lat = 0; s = '0; c = 1'b0; w = 0;
      while (bus.in_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         to = 1'b1;
         return;
      end
      bus.num1     = n1;
      bus.num2     = n2;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      forever begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.out_valid === 1'b1) break;
         if (lat > 50) begin
            to = 1'b1;
            return;
         end
      end
      s = bus.sum;
      c = bus.cout;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.num1 = '0; bus.num2 = '0;
      #3;
      total++; if (bus.in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);   else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
      total++; if (bus.sum !== 16'h0000)   $display("FAIL reset_sum: got %h want 0000", bus.sum);          else passed++;
      total++; if (bus.cout !== 1'b0)      $display("FAIL reset_cout: got %b want 0", bus.cout);           else passed++;
      repeat (2) @(negedge clk);
      total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL reset_hold: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_no_carry();
      int lat; logic [15:0] s; logic c; bit to;
      bus.out_ready = 1'b1;
      do_op(16'h00F0, 16'h000F, lat, s, c, to);
      total++; if (to)            $display("FAIL nc_timeout: got timeout want out_valid"); else passed++;
      total++; if (lat !== 4)     $display("FAIL nc_latency: got %0d want 4", lat);        else passed++;
      total++; if (s !== 16'h00FF) $display("FAIL nc_sum: got %h want 00ff", s);           else passed++;
      total++; if (c !== 1'b0)    $display("FAIL nc_cout: got %b want 0", c);              else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL nc_ready_in_done: got %b want 0", bus.in_ready); else passed++;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL nc_return_idle: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
      // Capture here lands 6 edges after the first capture.
      do_op(16'h1357, 16'h0246, lat, s, c, to);
      total++; if (to || lat !== 4 || {c, s} !== ref_add(16'h1357, 16'h0246))
         $display("FAIL nc_second_op: got lat=%0d %b_%h want lat=4 %h", lat, c, s, ref_add(16'h1357, 16'h0246)); else passed++;
      @(negedge clk);
   endtask

   task automatic test_full_ripple();
      int lat; logic [15:0] s; logic c; bit to;
      bus.out_ready = 1'b1;
      do_op(16'hFFFF, 16'h0001, lat, s, c, to);
      total++; if (to || lat !== 4) $display("FAIL ripple_latency: got %0d to=%b want 4", lat, to); else passed++;
      total++; if (s !== 16'h0000)  $display("FAIL ripple_sum: got %h want 0000", s);             else passed++;
      total++; if (c !== 1'b1)      $display("FAIL ripple_cout: got %b want 1", c);               else passed++;
      @(negedge clk);
      // Carry must not leak into the next operation.
      do_op(16'h0000, 16'h0000, lat, s, c, to);
      total++; if (to || s !== 16'h0000 || c !== 1'b0)
         $display("FAIL ripple_carry_cleared: got %b_%h want 0_0000", c, s); else passed++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int lat; logic [15:0] s; logic c; bit to;
      logic [15:0] a, b; logic [16:0] e;
      bit ok;
      a = 16'($urandom); b = 16'($urandom); e = ref_add(a, b);
      bus.out_ready = 1'b0;
      do_op(a, b, lat, s, c, to);
      total++; if (to || {c, s} !== e) $display("FAIL bp_result: got %b_%h want %h", c, s, e); else passed++;
      ok = 1'b1;
      bus.in_valid = 1'b1; bus.num1 = ~a; bus.num2 = 16'h5A5A;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || {bus.cout, bus.sum} !== e) ok = 1'b0;
      end
      total++; if (!ok) $display("FAIL bp_hold: got ov=%b ir=%b %b_%h want 1/0 %h",
                                bus.out_valid, bus.in_ready, bus.cout, bus.sum, e); else passed++;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
      a = 16'($urandom); b = 16'($urandom); e = ref_add(a, b);
      do_op(a, b, lat, s, c, to);
      total++; if (to || lat !== 4 || {c, s} !== e)
         $display("FAIL bp_next_op: got lat=%0d %b_%h want lat=4 %h", lat, c, s, e); else passed++;
      @(negedge clk);
   endtask

   task automatic test_random_stall();
      int lat; logic [15:0] s; logic c; bit to;
      logic [15:0] a, b; logic [16:0] e;
      int stall;
      bit ok;
      for (int n = 0; n < 200; n++) begin
         a = 16'($urandom); b = 16'($urandom);
         if (n % 10 == 0) b = ~a;
         e = ref_add(a, b);
         bus.out_ready = 1'b0;
         do_op(a, b, lat, s, c, to);
         total++; if (to || lat !== 4 || {c, s} !== e)
            $display("FAIL rnd_op%0d: got lat=%0d %b_%h want lat=4 %h", n, lat, c, s, e); else passed++;
         stall = $urandom_range(0, 3);
         ok = 1'b1;
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || {bus.cout, bus.sum} !== e) ok = 1'b0;
         end
         total++; if (!ok) $display("FAIL rnd_stall%0d: got %b_%h want %h", n, bus.cout, bus.sum, e); else passed++;
         bus.out_ready = 1'b1;
         @(negedge clk);
         bus.out_ready = 1'b0;
      end
   endtask

   task automatic test_chain();
      int lat; logic [15:0] s; logic c; bit to;
      logic [15:0] a, b, cc, d, cv, sv, e;
      logic [31:0] t;
      bus.out_ready = 1'b1;
      comp4_2(16'h1234, 16'h1111, 16'h0F0F, 16'h0001, cv, sv);
      do_op(cv, sv, lat, s, c, to);
      total++; if (to || s !== 16'h3255) $display("FAIL chain_fixed: got %h want 3255", s); else passed++;
      for (int n = 0; n < 1000; n++) begin
         a = 16'($urandom); b = 16'($urandom); cc = 16'($urandom); d = 16'($urandom);
         t = 32'(a) + 32'(b) + 32'(cc) + 32'(d);
         e = t[15:0];
         comp4_2(a, b, cc, d, cv, sv);
         do_op(cv, sv, lat, s, c, to);
         total++; if (to || s !== e) $display("FAIL chain_rnd%0d: got %h want %h", n, s, e); else passed++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat; logic [15:0] s; logic c; bit to;
      bit ok;
      bus.out_ready = 1'b1;
      bus.num1 = 16'hABCD; bus.num2 = 16'h1234; bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum !== 16'h0000 || bus.cout !== 1'b0)
         $display("FAIL midrst_async: ov=%b ir=%b %b_%h want 0/1 0_0000",
                  bus.out_valid, bus.in_ready, bus.cout, bus.sum); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
      end
      total++; if (!ok) $display("FAIL midrst_discard: ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
      do_op(16'h8000, 16'h8000, lat, s, c, to);
      total++; if (to || lat !== 4 || s !== 16'h0000 || c !== 1'b1)
         $display("FAIL midrst_after: got lat=%0d %b_%h want lat=4 1_0000", lat, c, s); else passed++;
      @(negedge clk);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_no_carry();
      test_full_ripple();
      test_backpressure();
      test_random_stall();
      test_chain();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cpa_seq_resolve.md
# cpa_seq_resolve

Sequential carry-propagate resolver that sits directly downstream of the carry-save compressor stages (`N_comp3_2` / `N_comp4_2`). It accepts a carry-save pair (`num1`, `num2`) over a valid/ready handshake. It sums the pair SEG bits per cycle with a registered inter-segment carry, so no full-width ripple path exists. It returns the N-bit binary result plus carry-out over a second valid/ready handshake.

## Interface
- `N`, 16: operand/result width; must be a multiple of `SEG`.
- `SEG`, 4: bits resolved per cycle; 1 ≤ `SEG` ≤ `N`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  `num1`/`num2` valid.
- `in_ready`  out  1  block can accept an operand pair.
- `num1`  in  N  carry vector (already left-shifted by the compressor).
- `num2`  in  N  sum vector.
- `out_valid`  out  1  `sum`/`cout` valid.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  N  (`num1` + `num2`) mod 2^N.
- `cout`  out  1  carry out of bit N-1.

## Operation
- The block has three states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - BUSY: `in_ready`=0, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- IDLE → BUSY on `in_valid && in_ready`:
  - Capture `num1`/`num2` into operand registers.
  - Clear the carry register.
  - Set the segment counter `seg_cnt` to 0.
- BUSY, each cycle:
  - Compute `{c, s}` = `num1_q`[seg] + `num2_q`[seg] + `carry_q`, where [seg] is bits `seg_cnt*SEG` +: `SEG`.
  - Write `s` into result bits [seg].
  - Load `c` into `carry_q`.
  - Increment `seg_cnt`.
- BUSY → DONE when `seg_cnt` == NSEG-1, where NSEG = N/SEG. On that edge the final `c` becomes `cout`.
- DONE → IDLE on `out_valid && out_ready`.
- In DONE, `sum` and `cout` are held stable until the handshake completes. They are undefined outside DONE, except at reset.
- `in_valid` is ignored while `in_ready`=0; there is no input buffering.
- Arithmetic is unsigned. Bits beyond N are reported only through `cout`.
- The carry never crosses operations; it is cleared at every capture.
- `in_ready` and `out_valid` are decoded from registered state only. They have no combinational dependence on `in_valid` or `out_ready`.

## Timing
- Reset (`rst_n`=0, asynchronous) forces, immediately and regardless of state:
  - state IDLE;
  - `in_ready`=1, `out_valid`=0;
  - `sum`=0, `cout`=0;
  - `seg_cnt`=0, `carry_q`=0, operand registers 0.
- Reset mid-BUSY or mid-DONE discards the operation; no result is delivered.
- Latency: capture at edge E0 → `out_valid`=1 after edge E0+NSEG (NSEG=4 with the defaults).
- With `out_ready` held 1: the handshake completes at edge E0+NSEG+1, and the next capture can occur at edge E0+NSEG+2. Minimum initiation interval is NSEG+2 cycles.
- With NSEG=1 (`SEG`=`N`), the block passes through BUSY for exactly one cycle.
- Backpressure: DONE persists indefinitely while `out_ready`=0, with outputs frozen.

## Structure
- Shared package `csa_pkg`:
  - state encoding (IDLE, BUSY, DONE);
  - localparam NSEG = N/SEG;
  - `seg_cnt` width = max(1, $clog2(NSEG)).
- Sub-module `seg_adder`: purely combinational, `SEG`-bit add with carry-in and carry-out.
- The top level holds the FSM, counter, operand registers, carry register and result register.

## Test plan
All scenarios use `N`=16, `SEG`=4.
- Reset: hold `rst_n`=0 → `in_ready`=1, `out_valid`=0, `sum`=0x0000, `cout`=0.
- No carry: `num1`=0x00F0, `num2`=0x000F, `out_ready`=1 → `out_valid` rises 4 cycles after capture, `sum`=0x00FF, `cout`=0; next capture allowed 6 cycles after the first.
- Full ripple: `num1`=0xFFFF, `num2`=0x0001 → `sum`=0x0000, `cout`=1, with the carry crossing all 4 segments.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid` → `sum`/`cout` stable and `in_ready`=0; a new `in_valid` is ignored. Raising `out_ready` completes the handshake and returns to IDLE in one cycle.
- Chain check:
  - Drive A=0x1234, B=0x1111, C=0x0F0F, D=0x0001 through `N_comp4_2` (N=16) into this block → `sum`=0x3255.
  - Repeat with 1000 random vectors against (A+B+C+D) mod 2^16.
  - `cout` is not checked in this scenario.
- Reset mid-operation: assert `rst_n`=0 in the 2nd BUSY cycle → `out_valid`=0, `in_ready`=1, `sum`=0 immediately. After release, `num1`=0x8000, `num2`=0x8000 → `sum`=0x0000, `cout`=1.
